sdram_port_arbiter: RTL

- Two-client arbiter that merges two toggle-handshake byte requesters onto a single toggle-handshake port of chameleon_sdram.
- Typical pairing: dma_engine on client 0 and mmc64 RAM access on client 1, sharing the cpu6510 port. This frees the cache port for other use.
- Round-robin fairness; one outstanding memory transaction at a time.
- Each completed read returns its data only to the client that issued it.

---
 rtl/sdram_port_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Merges two toggle-handshake byte clients onto one toggle-handshake SDRAM port.
// One transaction in flight at a time; ties resolved round-robin or fixed to client 0.
module sdram_port_arbiter #(
  parameter int a_bits         = 24,
  parameter int d_bits         = 8,
  parameter bit fixed_priority = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c0_req,
  output logic              c0_ack,
  input  logic              c0_we,
  input  logic [a_bits-1:0] c0_a,
  input  logic [d_bits-1:0] c0_d,
  output logic [d_bits-1:0] c0_q,
  input  logic              c1_req,
  output logic              c1_ack,
  input  logic              c1_we,
  input  logic [a_bits-1:0] c1_a,
  input  logic [d_bits-1:0] c1_d,
  output logic [d_bits-1:0] c1_q,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              mem_we,
  output logic [a_bits-1:0] mem_a,
  output logic [d_bits-1:0] mem_d,
  input  logic [d_bits-1:0] mem_q,
  output logic              busy
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t state_q, state_d;
  logic   last_grant;
  logic   gnt;
  logic   p0, p1;
  logic   do_grant, do_done, sel;

  assign p0 = c0_req ^ c0_ack;
  assign p1 = c1_req ^ c1_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Tie-break uses last_grant so the client served most recently yields.
  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    do_done  = 1'b0;
    sel      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (p0 || p1) begin
          do_grant = 1'b1;
          state_d  = ST_WAIT;
          if (p0 && p1) sel = fixed_priority ? 1'b0 : ~last_grant;
          else          sel = ~p0;
        end
      end
      ST_WAIT: begin
        if (mem_ack == mem_req) begin
          do_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- grant: capture client command and launch memory toggle ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_a      <= '0;
      mem_d      <= '0;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
    end else if (do_grant) begin
      mem_req    <= ~mem_req;
      mem_we     <= sel ? c1_we : c0_we;
      mem_a      <= sel ? c1_a  : c0_a;
      mem_d      <= sel ? c1_d  : c0_d;
      gnt        <= sel;
      last_grant <= sel;
    end
  end

  // ---- completion: return read data and acknowledge the granted client ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0_ack <= 1'b0;
      c1_ack <= 1'b0;
      c0_q   <= '0;
      c1_q   <= '0;
      busy   <= 1'b0;
    end else begin
      if (do_grant) busy <= 1'b1;
      if (do_done) begin
        busy <= 1'b0;
        if (gnt) begin
          c1_ack <= ~c1_ack;
          if (!mem_we) c1_q <= mem_q;
        end else begin
          c0_ack <= ~c0_ack;
          if (!mem_we) c0_q <= mem_q;
        end
      end
    end
  end

endmodule
